// File: rtl/block_sum_if.sv
// Pixel-in / block-sum-out bundle between the raster source, block_sum and the halftone renderer.
// Pure wiring, no latency; no backpressure, the source paces itself with pixelValid.
// master = pixel source / sum consumer side, slave = block_sum.
interface block_sum_if;
    logic        newFrame;
    logic [23:0] pixel;
    logic        pixelValid;
    logic [10:0] sum;
    logic        sumValid;
    logic [7:0]  blockCol;
    logic [7:0]  blockRow;
    logic        frameDone;

    modport master (
        output newFrame, pixel, pixelValid,
        input  sum, sumValid, blockCol, blockRow, frameDone
    );

    modport slave (
        input  newFrame, pixel, pixelValid,
        output sum, sumValid, blockCol, blockRow, frameDone
    );
endinterface

// File: rtl/block_sum.sv
// Reduces each 5x5 RGB pixel block to an 11-bit luma sum (optional R/G/B weighting: LUMA_WEIGHTED_EN).
// Latency: sum/sumValid registered on the edge that accepts the block's 25th pixel.
// No backpressure: pixelValid gaps simply freeze all state; pixels outside a frame are dropped.
module block_sum #(
    parameter int frameWidth  = 1120,
    parameter int frameHeight = 840,
    parameter int blockCols   = frameWidth / 5
) (
    input  logic       clk,
    input  logic       reset,
    block_sum_if.slave bus
);
    localparam int XW = $clog2(frameWidth);
    localparam int YW = $clog2(frameHeight);
    localparam int AW = (blockCols > 1) ? $clog2(blockCols) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(frameWidth - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(frameHeight - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_sub_x;
    logic [2:0]    r_sub_y;
    logic [7:0]    r_col;
    logic [7:0]    r_brow;
    logic [8:0]    r_hacc;
    logic [10:0]   r_buf [blockCols];

    logic [10:0]   r_sum;
    logic          r_sum_vld;
    logic [7:0]    r_bcol;
    logic [7:0]    r_brow_out;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_blk_done;
    logic          w_last;

    logic [XW-1:0] w_cx,   w_nx;
    logic [YW-1:0] w_cy,   w_ny;
    logic [2:0]    w_csx,  w_nsx;
    logic [2:0]    w_csy,  w_nsy;
    logic [7:0]    w_ccol, w_ncol;
    logic [7:0]    w_cbrow, w_nbrow;

    logic [5:0]    w_l6;
    logic [8:0]    w_row_sum;
    logic [AW-1:0] w_addr;
    logic [10:0]   w_buf_rd;
    logic [10:0]   w_buf_wr;
    logic [10:0]   w_blk_sum;

`ifdef LUMA_WEIGHTED_EN
    logic [9:0] w_l10;
    assign w_l10 = 10'(bus.pixel[23:16]) + {1'b0, bus.pixel[15:8], 1'b0} + 10'(bus.pixel[7:0]);
    assign w_l6  = 6'(w_l10 >> 4);
`else
    logic w_unused_rb;
    assign w_unused_rb = ^{bus.pixel[23:16], bus.pixel[9:8], bus.pixel[7:0]};
    assign w_l6        = bus.pixel[15:10];
`endif

    // newFrame makes this cycle's pixel (0,0), so every counter is seen as zero.
    always_comb begin : p_eff
        w_cx    = bus.newFrame ? '0 : r_x;
        w_cy    = bus.newFrame ? '0 : r_y;
        w_csx   = bus.newFrame ? '0 : r_sub_x;
        w_csy   = bus.newFrame ? '0 : r_sub_y;
        w_ccol  = bus.newFrame ? '0 : r_col;
        w_cbrow = bus.newFrame ? '0 : r_brow;
    end

    always_ff @(posedge clk or negedge reset) begin : p_state
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_state_nxt
        w_state_nxt = r_state;
        if (w_last) begin
            w_state_nxt = S_IDLE;
        end else if (bus.newFrame) begin
            w_state_nxt = S_ACTIVE;
        end
    end

    always_comb begin : p_state_out
        w_accept   = bus.pixelValid && ((r_state == S_ACTIVE) || bus.newFrame);
        w_blk_done = w_accept && (w_csx == 3'd4) && (w_csy == 3'd4);
        w_last     = w_accept && (w_cx == X_LAST) && (w_cy == Y_LAST);
    end

    always_comb begin : p_cnt_nxt
        w_nx    = w_cx;
        w_ny    = w_cy;
        w_nsx   = w_csx;
        w_nsy   = w_csy;
        w_ncol  = w_ccol;
        w_nbrow = w_cbrow;
        if (w_accept) begin
            if (w_cx == X_LAST) begin
                w_nx   = '0;
                w_nsx  = '0;
                w_ncol = '0;
                if (w_cy == Y_LAST) begin
                    w_ny    = '0;
                    w_nsy   = '0;
                    w_nbrow = '0;
                end else begin
                    w_ny = w_cy + YW'(1);
                    if (w_csy == 3'd4) begin
                        w_nsy   = '0;
                        w_nbrow = w_cbrow + 8'd1;
                    end else begin
                        w_nsy = w_csy + 3'd1;
                    end
                end
            end else begin
                w_nx = w_cx + XW'(1);
                if (w_csx == 3'd4) begin
                    w_nsx  = '0;
                    w_ncol = w_ccol + 8'd1;
                end else begin
                    w_nsx = w_csx + 3'd1;
                end
            end
        end
    end

    assign w_row_sum = r_hacc + {3'b000, w_l6};
    assign w_addr    = w_ccol[AW-1:0];
    assign w_buf_rd  = r_buf[w_addr];
    assign w_buf_wr  = (w_csy == 3'd0) ? {2'b00, w_row_sum} : (w_buf_rd + {2'b00, w_row_sum});
    assign w_blk_sum = w_buf_rd + {2'b00, w_row_sum};

    always_ff @(posedge clk or negedge reset) begin : p_cnt
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_sub_x <= '0;
            r_sub_y <= '0;
            r_col   <= '0;
            r_brow  <= '0;
            r_hacc  <= '0;
        end else begin
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_sub_x <= w_nsx;
            r_sub_y <= w_nsy;
            r_col   <= w_ncol;
            r_brow  <= w_nbrow;
            if (w_accept) begin
                r_hacc <= (w_csx == 3'd0) ? {3'b000, w_l6} : w_row_sum;
            end else if (bus.newFrame) begin
                r_hacc <= '0;
            end
        end
    end

    // Column partials need no reset: the first line of each block row overwrites them.
    always_ff @(posedge clk) begin : p_buf
        if (w_accept && (w_csx == 3'd4) && (w_csy != 3'd4)) begin
            r_buf[w_addr] <= w_buf_wr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : p_out
        if (!reset) begin
            r_sum        <= '0;
            r_sum_vld    <= 1'b0;
            r_bcol       <= '0;
            r_brow_out   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_sum_vld    <= w_blk_done;
            r_frame_done <= w_last;
            if (w_blk_done) begin
                r_sum      <= w_blk_sum;
                r_bcol     <= w_ccol;
                r_brow_out <= w_cbrow;
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.sumValid  = r_sum_vld;
    assign bus.blockCol  = r_bcol;
    assign bus.blockRow  = r_brow_out;
    assign bus.frameDone = r_frame_done;
endmodule

// File: tb/tb_block_sum.sv
// Self-checking bench for block_sum on a reduced 40x20 frame (8x4 blocks).
// Reference: per-block sum of per-pixel 6-bit luma over a stored image.
// Inputs driven on the falling edge, outputs checked on the following falling edge.
module tb_block_sum;
    localparam int W = 40;
    localparam int H = 20;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    block_sum_if bus ();

    block_sum #(
        .frameWidth (W),
        .frameHeight(H)
    ) dut (
        .clk  (clk),
        .reset(reset_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [23:0] img [H][W];

    function automatic int l6(input logic [23:0] p);
`ifdef LUMA_WEIGHTED_EN
        return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 16;
`else
        return int'(p[15:8]) / 4;
`endif
    endfunction

    function automatic int blk_sum(input int bx, input int by);
        int s = 0;
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 5; i++)
                s += l6(img[by*5+j][bx*5+i]);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_chk(input string tag);
        chk(tag, {30'd0, bus.sumValid, bus.frameDone}, 32'd0);
    endtask

    // 0 white, 1 black, 2 block checkerboard, 3 0x404040, 4 random, 5 0xFF00FF
    task automatic fill(input int pat);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (pat)
                    0: img[y][x] = 24'hFFFFFF;
                    1: img[y][x] = 24'h000000;
                    2: img[y][x] = (((x / 5) + (y / 5)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
                    3: img[y][x] = 24'h404040;
                    4: img[y][x] = 24'($urandom);
                    default: img[y][x] = 24'hFF00FF;
                endcase
    endtask

    task automatic send(input int x, input int y, input bit nf, input int gap_pct);
        bit done, fd;
        int g = 0;
        while (g < 8 && $urandom_range(99) < gap_pct) begin
            bus.pixelValid = 1'b0;
            bus.newFrame   = 1'b0;
            bus.pixel      = 24'($urandom);
            tick();
            quiet_chk("gap_quiet");
            g++;
        end
        bus.pixel      = img[y][x];
        bus.pixelValid = 1'b1;
        bus.newFrame   = nf;
        tick();
        bus.pixelValid = 1'b0;
        bus.newFrame   = 1'b0;
        done = (x % 5 == 4) && (y % 5 == 4);
        fd   = (x == W - 1) && (y == H - 1);
        chk("strobes", {30'd0, bus.sumValid, bus.frameDone}, {30'd0, done, fd});
        if (done) begin
            chk("sum",      32'(bus.sum),      32'(blk_sum(x / 5, y / 5)));
            chk("blockCol", 32'(bus.blockCol), 32'(x / 5));
            chk("blockRow", 32'(bus.blockRow), 32'(y / 5));
        end
    endtask

    task automatic run(input int nlines, input bit nf_same, input int gap_pct);
        if (!nf_same) begin
            bus.newFrame   = 1'b1;
            bus.pixelValid = 1'b0;
            tick();
            bus.newFrame = 1'b0;
            quiet_chk("nf_pulse");
        end
        for (int y = 0; y < nlines; y++)
            for (int x = 0; x < W; x++)
                send(x, y, nf_same && (x == 0) && (y == 0), gap_pct);
    endtask

    task automatic drop(input int n);
        bus.newFrame   = 1'b0;
        bus.pixelValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.pixel = 24'hFFFFFF;
            tick();
            quiet_chk("idle_drop");
        end
        bus.pixelValid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.newFrame   = 1'b0;
        bus.pixelValid = 1'b0;
        bus.pixel      = '0;
        repeat (3) tick();
        chk("rst_sumValid",  32'(bus.sumValid),  32'd0);
        chk("rst_frameDone", 32'(bus.frameDone), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_blockCol",  32'(bus.blockCol),  32'd0);
        chk("rst_blockRow",  32'(bus.blockRow),  32'd0);
        reset_n = 1'b1;
        tick();

        // Idle after reset: pixels without newFrame are dropped.
        drop(5 * W);

        // All white block row; last sum left on the outputs is cleared by async reset.
        fill(0);
        run(5, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        chk("arst_sumValid", 32'(bus.sumValid), 32'd0);
        chk("arst_sum",      32'(bus.sum),      32'd0);
        chk("arst_blockCol", 32'(bus.blockCol), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        drop(5 * W);

        // Full black frame, newFrame with the first pixel; frame end returns to idle.
        fill(1);
        run(H, 1'b1, 0);
        tick();
        quiet_chk("post_frame");
        drop(5 * W);

        fill(2);
        run(H, 1'b0, 30);
        tick();
        quiet_chk("post_checker");

        fill(3);
        run(H, 1'b1, 40);

        // Abort mid block row; stale partials must not leak into the restarted frame.
        fill(4);
        run(3, 1'b0, 0);
        for (int x = 0; x < 12; x++) send(x, 3, 1'b0, 0);
        fill(4);
        run(5, 1'b0, 10);
        fill(4);
        run(5, 1'b1, 0);

        fill(4);
        run(H, 1'b0, 20);

        fill(5);
        run(5, 1'b1, 0);
        tick();
        quiet_chk("final_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
